// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the control bundle carried through the decode stage.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] imm_src;
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode decoder producing the main control bundle.
module main_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [1:0] o_imm_src,
  output logic       o_reg_write,
  output logic       o_mem_write,
  output logic       o_alu_src,
  output logic       o_branch,
  output logic       o_jump,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_op,
  output logic       o_illegal
);

  always_comb begin
    o_imm_src    = IMM_I;
    o_reg_write  = 1'b0;
    o_mem_write  = 1'b0;
    o_alu_src    = 1'b0;
    o_branch     = 1'b0;
    o_jump       = 1'b0;
    o_result_src = RES_ALU;
    o_alu_op     = ALUOP_ADD;
    o_illegal    = 1'b0;
    case (i_opcode)
      OPC_LOAD: begin
        o_reg_write  = 1'b1;
        o_alu_src    = 1'b1;
        o_result_src = RES_MEM;
      end
      OPC_STORE: begin
        o_imm_src   = IMM_S;
        o_mem_write = 1'b1;
        o_alu_src   = 1'b1;
      end
      OPC_OP: begin
        o_reg_write = 1'b1;
        o_alu_op    = ALUOP_FUNCT;
      end
      OPC_OP_IMM: begin
        o_reg_write = 1'b1;
        o_alu_src   = 1'b1;
        o_alu_op    = ALUOP_FUNCT;
      end
      OPC_BRANCH: begin
        o_imm_src = IMM_B;
        o_branch  = 1'b1;
        o_alu_op  = ALUOP_SUB;
      end
      OPC_JAL: begin
        o_imm_src    = IMM_J;
        o_reg_write  = 1'b1;
        o_jump       = 1'b1;
        o_result_src = RES_PC4;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: main output register plus one skid entry, flush, and a
// saturating count of delivered illegal instructions.
module instr_decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [1:0]       imm_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             alu_src,
  output logic             branch,
  output logic             jump,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  ctrl_t w_dec_ctrl;

  main_decoder u_main_decoder (
    .i_opcode     (in_instr[6:0]),
    .o_imm_src    (w_dec_ctrl.imm_src),
    .o_reg_write  (w_dec_ctrl.reg_write),
    .o_mem_write  (w_dec_ctrl.mem_write),
    .o_alu_src    (w_dec_ctrl.alu_src),
    .o_branch     (w_dec_ctrl.branch),
    .o_jump       (w_dec_ctrl.jump),
    .o_result_src (w_dec_ctrl.result_src),
    .o_alu_op     (w_dec_ctrl.alu_op),
    .o_illegal    (w_dec_ctrl.illegal)
  );

  logic             r_main_valid;
  logic [31:0]      r_main_instr;
  logic [PC_W-1:0]  r_main_pc;
  ctrl_t            r_main_ctrl;
  logic             r_skid_valid;
  logic [31:0]      r_skid_instr;
  logic [PC_W-1:0]  r_skid_pc;
  ctrl_t            r_skid_ctrl;
  logic [CNT_W-1:0] r_cnt;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_main_free;

  // Ready depends only on held state, so no combinational path from out_ready.
  assign in_ready    = !reset && !r_skid_valid;
  assign w_in_xfer   = in_valid && in_ready;
  assign w_out_xfer  = r_main_valid && out_ready;
  assign w_main_free = !r_main_valid || w_out_xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_instr <= '0;
      r_main_pc    <= '0;
      r_main_ctrl  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_ctrl  <= '0;
      r_cnt        <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_out_xfer && r_main_ctrl.illegal && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_main_free) begin
        // Skid is older than anything arriving, and in_ready is low while it holds.
        if (r_skid_valid) begin
          r_main_valid <= 1'b1;
          r_main_instr <= r_skid_instr;
          r_main_pc    <= r_skid_pc;
          r_main_ctrl  <= r_skid_ctrl;
          r_skid_valid <= 1'b0;
        end else if (w_in_xfer) begin
          r_main_valid <= 1'b1;
          r_main_instr <= in_instr;
          r_main_pc    <= in_pc;
          r_main_ctrl  <= w_dec_ctrl;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_in_xfer) begin
        r_skid_valid <= 1'b1;
        r_skid_instr <= in_instr;
        r_skid_pc    <= in_pc;
        r_skid_ctrl  <= w_dec_ctrl;
      end
    end
  end

  assign out_valid   = r_main_valid;
  assign out_instr   = r_main_instr;
  assign out_pc      = r_main_pc;
  assign imm_src     = r_main_ctrl.imm_src;
  assign reg_write   = r_main_ctrl.reg_write;
  assign mem_write   = r_main_ctrl.mem_write;
  assign alu_src     = r_main_ctrl.alu_src;
  assign branch      = r_main_ctrl.branch;
  assign jump        = r_main_ctrl.jump;
  assign result_src  = r_main_ctrl.result_src;
  assign alu_op      = r_main_ctrl.alu_op;
  assign illegal     = r_main_ctrl.illegal;
  assign illegal_cnt = r_cnt;

endmodule
